// File: rtl/hack_mem_pkg.sv
// Shared address map, widths and region decode for the Hack data-side memory.
package hack_mem_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 15;

  localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
  localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;
  localparam logic [ADDR_W-1:0] RAM_LIMIT   = 15'h3FFF;

  typedef enum logic [1:0] {
    RegRam,
    RegScreen,
    RegKbd,
    RegNone
  } regionT;

  // Everything above the keyboard register is unmapped.
  function automatic regionT decodeRegion(input logic [ADDR_W-1:0] addr);
    if (addr <= RAM_LIMIT) return RegRam;
    if (addr < KBD_ADDR) return RegScreen;
    if (addr == KBD_ADDR) return RegKbd;
    return RegNone;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with asynchronous active-high reset. A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle; a pop on
// an empty FIFO is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  rdPtr;
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW:0]    count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FullCount);
  assign empty  = (count == '0);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign head   = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop) begin
        count <= count + 1'b1;
      end else if (doPop && !doPush) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/hack_data_memory.sv
// Data-side responder for the Hack CPU: RAM, screen shadow with a forwarding
// queue to the display sink, and a keyboard register fed by a key FIFO.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 16384,
  parameter int unsigned SCR_WORDS  = 8192,
  parameter int unsigned KBD_DEPTH  = 4,
  parameter int unsigned SCRQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addressM,
  input  logic [WORD_W-1:0] outM,
  input  logic              writeM,
  output logic [WORD_W-1:0] inM,
  input  logic              key_valid,
  input  logic [WORD_W-1:0] key_code,
  output logic              key_ready,
  output logic              scr_valid,
  output logic [12:0]       scr_addr,
  output logic [WORD_W-1:0] scr_data,
  input  logic              scr_ready,
  output logic              scr_overflow
);

  localparam int unsigned RamAw     = $clog2(RAM_WORDS);
  localparam int unsigned ScrAw     = $clog2(SCR_WORDS);
  localparam int unsigned ScrEntryW = ScrAw + WORD_W;

  logic [WORD_W-1:0] ramMem [RAM_WORDS];
  logic [WORD_W-1:0] scrMem [SCR_WORDS];

  regionT           region;
  logic [RamAw-1:0] ramIdx;
  logic [ScrAw-1:0] scrOffset;

  assign region    = decodeRegion(addressM);
  assign ramIdx    = RamAw'(addressM);
  assign scrOffset = ScrAw'(addressM - SCREEN_BASE);

  // Key FIFO: a zero scancode completes the handshake but is never stored.
  logic              keyFull;
  logic              keyEmpty;
  logic              keyPush;
  logic              keyPop;
  logic [WORD_W-1:0] keyHead;

  assign key_ready = ~keyFull;
  assign keyPush   = key_valid & key_ready & (key_code != '0);
  assign keyPop    = writeM & (region == RegKbd);

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (KBD_DEPTH)
  ) u_keyFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keyPush),
    .pop   (keyPop),
    .din   (key_code),
    .full  (keyFull),
    .empty (keyEmpty),
    .head  (keyHead)
  );

  // Screen write queue: entries are {offset, pixel word}.
  logic                 scrFull;
  logic                 scrEmpty;
  logic                 scrPush;
  logic                 scrPop;
  logic [ScrEntryW-1:0] scrHead;
  logic                 scrOverflowQ;

  assign scrPush   = writeM & (region == RegScreen);
  assign scrPop    = scr_valid & scr_ready;
  assign scr_valid = ~scrEmpty;
  assign {scr_addr, scr_data} = scrHead;
  assign scr_overflow = scrOverflowQ;

  sync_fifo #(
    .WIDTH (ScrEntryW),
    .DEPTH (SCRQ_DEPTH)
  ) u_scrFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (scrPush),
    .pop   (scrPop),
    .din   ({scrOffset, outM}),
    .full  (scrFull),
    .empty (scrEmpty),
    .head  (scrHead)
  );

  // Sticky drop flag: a screen write found the queue full with nothing leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scrOverflowQ <= 1'b0;
    end else if (scrPush && scrFull && !scrPop) begin
      scrOverflowQ <= 1'b1;
    end
  end

  // RAM and screen shadow commit on the write edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (writeM && region == RegRam) ramMem[ramIdx] <= outM;
    if (writeM && region == RegScreen) scrMem[scrOffset] <= outM;
  end

  // Zero-latency read mux; the CPU consumes inM in the same cycle.
  always_comb begin
    inM = '0;
    unique case (region)
      RegRam:    inM = ramMem[ramIdx];
      RegScreen: inM = scrMem[scrOffset];
      RegKbd:    inM = keyEmpty ? '0 : keyHead;
      default:   inM = '0;
    endcase
  end

endmodule

// File: tb/tb_hack_data_memory.sv
// Self-checking bench for hack_data_memory against a queue/array reference model.
module tb_hack_data_memory;

  localparam int KbdDepth  = 4;
  localparam int ScrqDepth = 4;

  logic        clk;
  logic        rst;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        key_valid;
  logic [15:0] key_code;
  logic        key_ready;
  logic        scr_valid;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ready;
  logic        scr_overflow;

  hack_data_memory dut (
    .clk          (clk),
    .rst          (rst),
    .addressM     (addressM),
    .outM         (outM),
    .writeM       (writeM),
    .inM          (inM),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .scr_valid    (scr_valid),
    .scr_addr     (scr_addr),
    .scr_data     (scr_data),
    .scr_ready    (scr_ready),
    .scr_overflow (scr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;

  // Reference model
  logic [15:0] ramM [16384];
  bit          ramK [16384];
  logic [15:0] scrM [8192];
  bit          scrK [8192];
  logic [15:0] keyQ [$];
  logic [28:0] scrQ [$];
  bit          ovfM;

  function automatic logic [15:0] expRead(input logic [14:0] a);
    if (a < 15'h4000) return ramM[a[13:0]];
    if (a < 15'h6000) return scrM[13'(a - 15'h4000)];
    if (a == 15'h6000) return (keyQ.size() > 0) ? keyQ[0] : 16'h0000;
    return 16'h0000;
  endfunction

  function automatic bit known(input logic [14:0] a);
    if (a < 15'h4000) return ramK[a[13:0]];
    if (a < 15'h6000) return scrK[13'(a - 15'h4000)];
    return 1'b1;
  endfunction

  task automatic modelReset();
    keyQ.delete();
    scrQ.delete();
    ovfM = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic clockStep();
    logic [14:0] a;
    logic [15:0] d;
    logic [15:0] kc;
    logic [12:0] off;
    bit          w;
    bit          kPush;
    bit          sPop;
    a     = addressM;
    d     = outM;
    w     = writeM;
    kc    = key_code;
    kPush = key_valid && (keyQ.size() < KbdDepth) && (key_code != 16'h0);
    sPop  = scr_ready && (scrQ.size() > 0);
    @(posedge clk);
    if (sPop) void'(scrQ.pop_front());
    if (w) begin
      if (a < 15'h4000) begin
        ramM[a[13:0]] = d;
        ramK[a[13:0]] = 1'b1;
      end else if (a < 15'h6000) begin
        off = 13'(a - 15'h4000);
        scrM[off] = d;
        scrK[off] = 1'b1;
        if (scrQ.size() < ScrqDepth) scrQ.push_back({off, d});
        else ovfM = 1'b1;
      end else if (a == 15'h6000) begin
        if (keyQ.size() > 0) void'(keyQ.pop_front());
      end
    end
    if (kPush) keyQ.push_back(kc);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    modelReset();
    addressM = 15'h6000;
    #1;
    totalCnt++;
    if (key_ready !== 1'b1) $display("FAIL reset_key_ready: got %b want 1", key_ready);
    else passCnt++;
    totalCnt++;
    if (scr_valid !== 1'b0) $display("FAIL reset_scr_valid: got %b want 0", scr_valid);
    else passCnt++;
    totalCnt++;
    if (scr_overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", scr_overflow);
    else passCnt++;
    totalCnt++;
    if (inM !== 16'h0000) $display("FAIL reset_kbd_read: got %h want 0000", inM);
    else passCnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ram();
    logic [14:0] addrs [8];
    addressM = 15'h0010;
    outM     = 16'h1234;
    writeM   = 1'b1;
    clockStep();
    writeM = 1'b0;
    #1;
    totalCnt++;
    if (inM !== 16'h1234) $display("FAIL ram_write_read: got %h want 1234", inM);
    else passCnt++;
    addressM = 15'h7000;
    #1;
    totalCnt++;
    if (inM !== 16'h0000) $display("FAIL unmapped_read: got %h want 0000", inM);
    else passCnt++;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 15'($urandom_range(0, 16'h3FFF));
      addressM = addrs[i];
      outM     = 16'($urandom);
      writeM   = 1'b1;
      clockStep();
    end
    writeM = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addressM = addrs[i];
      #1;
      totalCnt++;
      if (inM !== expRead(addrs[i]))
        $display("FAIL ram_random_read: addr %h got %h want %h", addrs[i], inM, expRead(addrs[i]));
      else passCnt++;
      clockStep();
    end
  endtask

  task automatic test_kbd();
    key_valid = 1'b1;
    key_code  = 16'h0041;
    clockStep();
    key_code = 16'h0000;
    clockStep();
    key_code = 16'h0042;
    clockStep();
    key_valid = 1'b0;
    addressM  = 15'h6000;
    #1;
    totalCnt++;
    if (inM !== 16'h0041 || inM !== expRead(15'h6000))
      $display("FAIL kbd_head_first: got %h want 0041", inM);
    else passCnt++;
    writeM = 1'b1;
    clockStep();
    writeM = 1'b0;
    #1;
    totalCnt++;
    if (inM !== 16'h0042) $display("FAIL kbd_head_second: got %h want 0042", inM);
    else passCnt++;
    writeM = 1'b1;
    clockStep();
    #1;
    totalCnt++;
    if (inM !== 16'h0000) $display("FAIL kbd_empty_read: got %h want 0000", inM);
    else passCnt++;
    clockStep();
    writeM = 1'b0;
    #1;
    totalCnt++;
    if (inM !== 16'h0000 || key_ready !== 1'b1)
      $display("FAIL kbd_pop_empty: inM %h key_ready %b want 0000/1", inM, key_ready);
    else passCnt++;
  endtask

  task automatic test_kbd_full();
    addressM  = 15'h6000;
    key_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key_code = 16'h0100 + 16'(i);
      clockStep();
      totalCnt++;
      if (key_ready !== (keyQ.size() < KbdDepth))
        $display("FAIL kbd_fill_ready: push %0d got %b want %b", i, key_ready,
                 keyQ.size() < KbdDepth);
      else passCnt++;
    end
    totalCnt++;
    if (key_ready !== 1'b0 || keyQ.size() != 4)
      $display("FAIL kbd_full_hold: key_ready %b depth %0d want 0/4", key_ready, keyQ.size());
    else passCnt++;
    // Pop while full with the fifth key still offered: no push that cycle.
    writeM = 1'b1;
    clockStep();
    writeM = 1'b0;
    #1;
    totalCnt++;
    if (key_ready !== 1'b1) $display("FAIL kbd_pop_frees: got %b want 1", key_ready);
    else passCnt++;
    clockStep();
    key_valid = 1'b0;
    for (int i = 0; i < 8 && keyQ.size() > 0; i++) begin
      #1;
      totalCnt++;
      if (inM !== expRead(15'h6000))
        $display("FAIL kbd_drain_order: got %h want %h", inM, expRead(15'h6000));
      else passCnt++;
      writeM = 1'b1;
      clockStep();
      writeM = 1'b0;
    end
    #1;
    totalCnt++;
    if (inM !== 16'h0000 || keyQ.size() != 0)
      $display("FAIL kbd_drained: got %h want 0000", inM);
    else passCnt++;
  endtask

  task automatic test_screen_single();
    scr_ready = 1'b1;
    addressM  = 15'h4005;
    outM      = 16'hFFFF;
    writeM    = 1'b1;
    clockStep();
    writeM = 1'b0;
    #1;
    totalCnt++;
    if (scr_valid !== 1'b1 || scr_addr !== 13'd5 || scr_data !== 16'hFFFF)
      $display("FAIL scr_single_head: valid %b addr %h data %h want 1/0005/ffff",
               scr_valid, scr_addr, scr_data);
    else passCnt++;
    totalCnt++;
    if (inM !== 16'hFFFF) $display("FAIL scr_shadow_read: got %h want ffff", inM);
    else passCnt++;
    clockStep();
    totalCnt++;
    if (scr_valid !== 1'b0) $display("FAIL scr_single_drain: got %b want 0", scr_valid);
    else passCnt++;
  endtask

  task automatic test_screen_overflow();
    logic [15:0] vals [5];
    scr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vals[i]  = 16'($urandom);
      addressM = 15'h4100 + 15'(i);
      outM     = vals[i];
      writeM   = 1'b1;
      clockStep();
      totalCnt++;
      if ({scr_addr, scr_data} !== scrQ[0] || scr_valid !== 1'b1)
        $display("FAIL scr_head_stable: got %h/%h want %h", scr_addr, scr_data, scrQ[0]);
      else passCnt++;
    end
    writeM = 1'b0;
    totalCnt++;
    if (scr_overflow !== 1'b1 || ovfM !== 1'b1)
      $display("FAIL scr_overflow_set: got %b want 1", scr_overflow);
    else passCnt++;
    for (int i = 0; i < 5; i++) begin
      addressM = 15'h4100 + 15'(i);
      #1;
      totalCnt++;
      if (inM !== vals[i]) $display("FAIL scr_shadow_all: idx %0d got %h want %h", i, inM, vals[i]);
      else passCnt++;
    end
    scr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      totalCnt++;
      if (scr_valid !== 1'b1 || scr_addr !== 13'(16'h0100 + i) || scr_data !== vals[i])
        $display("FAIL scr_drain_order: entry %0d got %b/%h/%h want 1/%h/%h", i, scr_valid,
                 scr_addr, scr_data, 13'(16'h0100 + i), vals[i]);
      else passCnt++;
      clockStep();
    end
    totalCnt++;
    if (scr_valid !== 1'b0 || scr_overflow !== 1'b1)
      $display("FAIL scr_drained_sticky: valid %b ovf %b want 0/1", scr_valid, scr_overflow);
    else passCnt++;
  endtask

  task automatic test_reset_midway();
    scr_ready = 1'b0;
    key_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_code = 16'h0200 + 16'(i);
      if (i == 2) key_valid = 1'b0;
      addressM = 15'h4200 + 15'(i);
      outM     = 16'($urandom);
      writeM   = 1'b1;
      clockStep();
    end
    writeM   = 1'b0;
    addressM = 15'h6000;
    #1;
    totalCnt++;
    if (inM !== 16'h0200 || scr_valid !== 1'b1 || keyQ.size() != 2 || scrQ.size() != 3)
      $display("FAIL midway_setup: inM %h valid %b want 0200/1", inM, scr_valid);
    else passCnt++;
    #1;
    rst = 1'b1;
    modelReset();
    #1;
    totalCnt++;
    if (key_ready !== 1'b1 || scr_valid !== 1'b0 || scr_overflow !== 1'b0 || inM !== 16'h0000)
      $display("FAIL midway_reset: ready %b valid %b ovf %b inM %h want 1/0/0/0000",
               key_ready, scr_valid, scr_overflow, inM);
    else passCnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) addressM = 15'($urandom_range(0, 31));
      else if (sel < 8) addressM = 15'h4000 + 15'($urandom_range(0, 31));
      else if (sel == 8) addressM = 15'h6000;
      else addressM = 15'($urandom_range(32'h6001, 32'h7FFF));
      outM      = 16'($urandom);
      writeM    = ($urandom_range(0, 9) < 4);
      key_valid = 1'($urandom_range(0, 1));
      key_code  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      scr_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (known(addressM)) begin
        totalCnt++;
        if (inM !== expRead(addressM))
          $display("FAIL rand_read: cycle %0d addr %h got %h want %h", i, addressM, inM,
                   expRead(addressM));
        else passCnt++;
      end
      totalCnt++;
      if (key_ready !== (keyQ.size() < KbdDepth))
        $display("FAIL rand_key_ready: cycle %0d got %b", i, key_ready);
      else passCnt++;
      totalCnt++;
      if (scr_valid !== (scrQ.size() > 0))
        $display("FAIL rand_scr_valid: cycle %0d got %b", i, scr_valid);
      else passCnt++;
      if (scrQ.size() > 0) begin
        totalCnt++;
        if ({scr_addr, scr_data} !== scrQ[0])
          $display("FAIL rand_scr_head: cycle %0d got %h/%h want %h", i, scr_addr, scr_data,
                   scrQ[0]);
        else passCnt++;
      end
      totalCnt++;
      if (scr_overflow !== ovfM)
        $display("FAIL rand_overflow: cycle %0d got %b want %b", i, scr_overflow, ovfM);
      else passCnt++;
      clockStep();
    end
  endtask

  initial begin
    rst       = 1'b0;
    addressM  = '0;
    outM      = '0;
    writeM    = 1'b0;
    key_valid = 1'b0;
    key_code  = '0;
    scr_ready = 1'b0;
    ovfM      = 1'b0;
    test_reset();
    test_ram();
    test_kbd();
    test_kbd_full();
    test_screen_single();
    test_screen_overflow();
    test_reset_midway();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
